// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back arbiter and its FIFO.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LU   = 2'd2
  } wb_src_e;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of result, register-file and scoreboard signals around the write-back arbiter.
interface writeback_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             ALU_VALID;
  logic [4:0]       ALU_REG;
  logic [XLEN-1:0]  ALU_DATA;
  logic             LU_VALID;
  logic             LU_READY;
  logic [4:0]       LU_REG;
  logic [XLEN-1:0]  LU_DATA;
  logic             WRITE_ENABLE;
  logic [4:0]       WRITE_REG;
  logic [XLEN-1:0]  WRITE_DATA;
  logic [CNT_W-1:0] PENDING_COUNT;
  logic             ISSUE_VALID;
  logic [4:0]       ISSUE_REG;
  logic [4:0]       CHECK_RS1;
  logic [4:0]       CHECK_RS2;
  logic [4:0]       CHECK_RD;
  logic             STALL;

  // Pipeline side: produces results and issue queries.
  modport master (
    output ALU_VALID, ALU_REG, ALU_DATA,
    output LU_VALID, LU_REG, LU_DATA,
    output ISSUE_VALID, ISSUE_REG, CHECK_RS1, CHECK_RS2, CHECK_RD,
    input  LU_READY, WRITE_ENABLE, WRITE_REG, WRITE_DATA, PENDING_COUNT, STALL
  );

  // Arbiter side.
  modport slave (
    input  ALU_VALID, ALU_REG, ALU_DATA,
    input  LU_VALID, LU_REG, LU_DATA,
    input  ISSUE_VALID, ISSUE_REG, CHECK_RS1, CHECK_RS2, CHECK_RD,
    output LU_READY, WRITE_ENABLE, WRITE_REG, WRITE_DATA, PENDING_COUNT, STALL
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular-buffer skid FIFO holding long-latency results awaiting the write port.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: ALU results first, long-latency results via skid FIFO or bypass.
// Optional register scoreboard enabled by defining WB_SCOREBOARD_EN.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  writeback_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  entry_t           fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;
  logic             lu_ready, lu_xfer, lu_nonzero;
  logic             alu_win, fifo_pop, bypass, fifo_push;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  wb_src_e               src_q, src_d;
  logic                  wb_src_lu;

  // Ready looks only at the registered count, so a full FIFO refuses even on a pop cycle.
  assign lu_ready   = !RST && !fifo_full;
  assign lu_xfer    = bus.LU_VALID && lu_ready;
  assign lu_nonzero = (bus.LU_REG != '0);

  assign alu_win   = bus.ALU_VALID && (bus.ALU_REG != '0);
  assign fifo_pop  = !RST && !alu_win && !fifo_empty;
  assign bypass    = !alu_win && fifo_empty && lu_xfer && lu_nonzero;
  assign fifo_push = lu_xfer && lu_nonzero && !bypass;

  assign fifo_wdata.rd   = bus.LU_REG;
  assign fifo_wdata.data = bus.LU_DATA;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    src_d   = SRC_NONE;
    if (alu_win) begin
      we_d    = 1'b1;
      wreg_d  = bus.ALU_REG;
      wdata_d = bus.ALU_DATA;
      src_d   = SRC_ALU;
    end else if (fifo_pop) begin
      we_d    = 1'b1;
      wreg_d  = fifo_rdata.rd;
      wdata_d = fifo_rdata.data;
      src_d   = SRC_LU;
    end else if (bypass) begin
      we_d    = 1'b1;
      wreg_d  = bus.LU_REG;
      wdata_d = bus.LU_DATA;
      src_d   = SRC_LU;
    end
  end

  // Output register stage feeding the register file write port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      src_q   <= SRC_NONE;
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
    end
  end

  assign wb_src_lu = (src_q == SRC_LU);

  assign bus.LU_READY      = lu_ready;
  assign bus.WRITE_ENABLE  = we_q;
  assign bus.WRITE_REG     = wreg_q;
  assign bus.WRITE_DATA    = wdata_q;
  assign bus.PENDING_COUNT = fifo_count;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pend_q, pend_d;
  logic [31:0] set_vec, clr_vec;

  // Clear lands on the edge the register file commits; a same-edge issue re-arms the bit.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.ISSUE_VALID && (bus.ISSUE_REG != '0)) set_vec[bus.ISSUE_REG] = 1'b1;
    if (we_q && wb_src_lu) clr_vec[wreg_q] = 1'b1;
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge CLK) begin
    if (RST) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign bus.STALL = ((bus.CHECK_RS1 != '0) && pend_q[bus.CHECK_RS1]) ||
                     ((bus.CHECK_RS2 != '0) && pend_q[bus.CHECK_RS2]) ||
                     ((bus.CHECK_RD  != '0) && pend_q[bus.CHECK_RD]);
`else
  logic unused_sb;
  assign unused_sb = ^{bus.ISSUE_VALID, bus.ISSUE_REG, bus.CHECK_RS1,
                       bus.CHECK_RS2, bus.CHECK_RD, wb_src_lu};
  assign bus.STALL = 1'b0;
`endif
endmodule
